// File: rtl/clock_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clock_period_meter
// Brief    : Avalon-MM slave measuring period and high time of meas_in in clk cycles.
// Revision : 1.0
// ============================================================================
module clock_period_meter #(
   parameter int CNT_WIDTH   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic [1:0]  address,
   input  logic        write,
   input  logic        read,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        meas_in
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   meas_prev;
   logic                   rise;
   logic                   fall;

   logic [1:0]             state;
   logic [1:0]             state_next;
   logic [CNT_WIDTH-1:0]   cnt;
   logic [CNT_WIDTH-1:0]   period;
   logic [CNT_WIDTH-1:0]   high;
   logic                   en;
   logic                   valid;
   logic                   ovf;

   logic                   wr_ctrl;
   logic                   clr;
   logic                   rd;
   logic                   cnt_zero;
   logic                   cnt_load;
   logic                   cnt_inc;
   logic                   cap_period;
   logic                   cap_high;
   logic                   set_ovf;
   logic [31:0]            period_ext;
   logic [31:0]            high_ext;
   logic                   unused_writedata;

   assign wr_ctrl          = chipselect & write & (address == 2'd0);
   assign clr              = wr_ctrl & writedata[1];
   assign rd               = chipselect & read;
   assign unused_writedata = ^writedata[31:2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         meas_prev <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], meas_in};
         meas_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~meas_prev;
   assign fall = ~sync_q[SYNC_STAGES-1] & meas_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   // A clear overrides everything and re-arms from the newly written EN.
   always_comb begin
      state_next = state;
      if (clr) begin
         state_next = writedata[0] ? ST_ARM : ST_IDLE;
      end else if (!en) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_next = ST_ARM;
            ST_ARM:  if (rise) state_next = ST_MEAS;
            ST_MEAS: if (!rise && cnt == CNT_MAX) state_next = ST_ARM;
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_zero   = 1'b0;
      cnt_load   = 1'b0;
      cnt_inc    = 1'b0;
      cap_period = 1'b0;
      cap_high   = 1'b0;
      set_ovf    = 1'b0;
      if (clr || !en) begin
         cnt_zero = 1'b1;
      end else begin
         case (state)
            ST_ARM: cnt_load = rise;
            ST_MEAS: begin
               cap_high = fall;
               if (rise) begin
                  cap_period = 1'b1;
                  cnt_load   = 1'b1;
               end else if (cnt == CNT_MAX) begin
                  set_ovf  = 1'b1;
                  cnt_zero = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: cnt_zero = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         en     <= 1'b0;
         cnt    <= '0;
         period <= '0;
         high   <= '0;
         valid  <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (wr_ctrl) en <= writedata[0];

         if (cnt_zero)      cnt <= '0;
         else if (cnt_load) cnt <= CNT_ONE;
         else if (cnt_inc)  cnt <= cnt + CNT_ONE;

         if (clr) begin
            period <= '0;
            high   <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
         end else begin
            if (cap_period) begin
               period <= cnt;
               valid  <= 1'b1;
            end
            if (cap_high) high <= cnt;
            if (set_ovf)  ovf  <= 1'b1;
         end
      end
   end

   always_comb begin
      period_ext                = '0;
      high_ext                  = '0;
      period_ext[CNT_WIDTH-1:0] = period;
      high_ext[CNT_WIDTH-1:0]   = high;
   end

   // Reads sample the registers before any same-cycle capture lands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else if (rd) begin
         case (address)
            2'd0:    readdata <= {31'd0, en};
            2'd1:    readdata <= {30'd0, ovf, valid};
            2'd2:    readdata <= period_ext;
            default: readdata <= high_ext;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_meter
// Brief    : Randomized self-checking bench for clock_period_meter (CNT_WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_clock_period_meter;

   localparam int CW   = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        chipselect = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        meas_in = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: what software should see, derived from waveform shape.
   int m_period = 0;
   int m_high   = 0;
   bit m_valid  = 1'b0;
   bit m_ovf    = 1'b0;

   clock_period_meter #(.CNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write      (write),
      .read       (read),
      .writedata  (writedata),
      .readdata   (readdata),
      .meas_in    (meas_in)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; writedata = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1; read = 1'b1; address = a;
      @(negedge clk);
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   // reps full periods of n cycles with h high, then a closing rise held high.
   task automatic drive_wave(input int n, input int h, input int reps);
      for (int r = 0; r < reps; r++) begin
         meas_in = 1'b1;
         repeat (h) @(negedge clk);
         meas_in = 1'b0;
         repeat (n - h) @(negedge clk);
      end
      meas_in = 1'b1;
   endtask

   task automatic model_wave(input int n, input int h);
      if (h <= CMAX) m_high = h;
      if (n <= CMAX) begin
         m_period = n;
         m_valid  = 1'b1;
      end else begin
         m_ovf = 1'b1;
      end
   endtask

   task automatic model_clear();
      m_period = 0; m_high = 0; m_valid = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic quiesce();
      meas_in = 1'b0;
      idle(4);
      bus_write(2'd0, 32'h2);
      model_clear();
      idle(2);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset_n = 1'b0;
      idle(3);
      n_checks++;
      if (readdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_readdata: got %0h expected 0", readdata);
      end
      reset_n = 1'b1;
      idle(2);
      for (int a = 0; a < 4; a++) begin
         bus_read(a[1:0], d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_reg%0d: got %0h expected 0", a, d);
         end
      end
   endtask

   task automatic test_registers();
      logic [31:0] d;
      bus_write(2'd0, 32'h3);
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'd1) begin
         n_fail++; $display("FAIL ctrl_clr_reads0: got %0h expected 1", d);
      end
      bus_write(2'd0, 32'hFFFF_FFFE);
      bus_read(2'd0, d);
      n_checks++;
      if (d !== 32'd0) begin
         n_fail++; $display("FAIL ctrl_upper_bits: got %0h expected 0", d);
      end
      for (int a = 1; a < 4; a++) bus_write(a[1:0], 32'hFFFF_FFFF);
      for (int a = 1; a < 4; a++) begin
         bus_read(a[1:0], d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++; $display("FAIL ro_write%0d: got %0h expected 0", a, d);
         end
      end
      bus_write(2'd0, 32'h1);
      bus_read(2'd0, d);
      @(negedge clk);
      read = 1'b1; address = 2'd1;
      idle(2);
      read = 1'b0;
      n_checks++;
      if (readdata !== 32'd1) begin
         n_fail++; $display("FAIL read_no_cs_hold: got %0h expected 1", readdata);
      end
   endtask

   task automatic test_basic();
      logic [31:0] d;
      quiesce();
      bus_write(2'd0, 32'h1);
      drive_wave(4, 2, 2);
      model_wave(4, 2);
      idle(4);
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd4) begin n_fail++; $display("FAIL basic_period: got %0d expected 4", d); end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== 32'd2) begin n_fail++; $display("FAIL basic_high: got %0d expected 2", d); end
      bus_read(2'd1, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL basic_status: got %0h expected 1", d); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      int n, h;
      int ns[$] = '{255, 256};
      for (int i = 0; i < 8; i++) begin
         if (i < 2) n = ns[i];
         else       n = $urandom_range(300, 2);
         h = $urandom_range(n - 1, 1);
         quiesce();
         bus_write(2'd0, 32'h1);
         drive_wave(n, h, 2);
         model_wave(n, h);
         idle(4);
         bus_read(2'd2, d);
         n_checks++;
         if (d !== 32'(m_period)) begin
            n_fail++; $display("FAIL rand_period n=%0d h=%0d: got %0d expected %0d", n, h, d, m_period);
         end
         bus_read(2'd3, d);
         n_checks++;
         if (d !== 32'(m_high)) begin
            n_fail++; $display("FAIL rand_high n=%0d h=%0d: got %0d expected %0d", n, h, d, m_high);
         end
         bus_read(2'd1, d);
         n_checks++;
         if (d !== {30'd0, m_ovf, m_valid}) begin
            n_fail++; $display("FAIL rand_status n=%0d h=%0d: got %0h expected %0h", n, h, d, {m_ovf, m_valid});
         end
      end
   endtask

   // Divider model: output toggles every div clk cycles, so its period is 2*div.
   task automatic test_loop();
      logic [31:0] dp, dh;
      for (int div = 2; div <= 3; div++) begin
         quiesce();
         bus_write(2'd0, 32'h1);
         for (int t = 0; t < 5; t++) begin
            meas_in = ~meas_in;
            repeat (div) @(negedge clk);
         end
         bus_read(2'd2, dp);
         bus_read(2'd3, dh);
         n_checks++;
         if (dp !== 32'(2 * div)) begin
            n_fail++; $display("FAIL loop_period div=%0d: got %0d expected %0d", div, dp, 2 * div);
         end
         n_checks++;
         if (dh !== 32'(div) || (dp - dh) !== 32'(div)) begin
            n_fail++; $display("FAIL loop_duty div=%0d: got high %0d expected %0d", div, dh, div);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      quiesce();
      bus_write(2'd0, 32'h1);
      drive_wave(10, 4, 1);
      model_wave(10, 4);
      idle(245);
      bus_read(2'd1, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL ovf_early: got %0h expected 1", d); end
      idle(15);
      bus_read(2'd1, d);
      n_checks++;
      if (d !== 32'd3) begin n_fail++; $display("FAIL ovf_status: got %0h expected 3", d); end
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd10) begin n_fail++; $display("FAIL ovf_period_kept: got %0d expected 10", d); end
   endtask

   task automatic test_clear();
      logic [31:0] d;
      int n, h;
      n = $urandom_range(40, 6);
      h = $urandom_range(n - 1, 1);
      quiesce();
      bus_write(2'd0, 32'h1);
      drive_wave(n, h, 1);
      meas_in = 1'b0;
      repeat (n - h) @(negedge clk);
      // Rise at this edge reaches the FSM three clocks later, together with CLR.
      meas_in = 1'b1;
      idle(2);
      chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h3;
      @(negedge clk);
      chipselect = 1'b0; write = 1'b0; writedata = '0;
      model_clear();
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL clr_period: got %0d expected 0", d); end
      bus_read(2'd1, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL clr_status: got %0h expected 0", d); end
      meas_in = 1'b0;
      idle(5);
      drive_wave(n + 3, h, 1);
      model_wave(n + 3, h);
      idle(4);
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'(m_period)) begin
         n_fail++; $display("FAIL clr_remeasure: got %0d expected %0d", d, m_period);
      end
   endtask

   task automatic test_disable_reset();
      logic [31:0] d;
      quiesce();
      bus_write(2'd0, 32'h1);
      drive_wave(20, 7, 1);
      model_wave(20, 7);
      idle(4);
      bus_write(2'd0, 32'h0);
      drive_wave(50, 30, 2);
      idle(4);
      bus_read(2'd2, d);
      n_checks++;
      if (d !== 32'd20) begin n_fail++; $display("FAIL dis_period: got %0d expected 20", d); end
      bus_read(2'd3, d);
      n_checks++;
      if (d !== 32'd7) begin n_fail++; $display("FAIL dis_high: got %0d expected 7", d); end
      bus_read(2'd1, d);
      n_checks++;
      if (d !== 32'd1) begin n_fail++; $display("FAIL dis_status: got %0h expected 1", d); end
      meas_in = 1'b0;
      bus_write(2'd0, 32'h1);
      drive_wave(12, 5, 1);
      idle(3);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (readdata !== 32'd0) begin n_fail++; $display("FAIL rst_mid_readdata: got %0h expected 0", readdata); end
      meas_in = 1'b0;
      idle(2);
      reset_n = 1'b1;
      model_clear();
      for (int a = 0; a < 4; a++) begin
         bus_read(a[1:0], d);
         n_checks++;
         if (d !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_reg%0d: got %0h expected 0", a, d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_registers();
      test_basic();
      test_random();
      test_loop();
      test_overflow();
      test_clear();
      test_disable_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
